// File: rtl/mult_ctrl_param.sv
// Parametrised sequencer for the shift-and-add multiplier datapath, with a start/busy/done handshake.
// Optional build macro MULT_CTRL_EARLY_EXIT_EN: CHECK also finishes once the multiplier register is zero.
//
// state | meaning
// IDLE  | waiting for i_start
// LOAD  | operands into working registers, iteration count cleared
// TEST  | multiplier LSB presented, choose ADD or SHIFT
// ADD   | accumulate multiplicand into product
// SHIFT | shift product/multiplier, count the iteration
// CHECK | decide between another iteration and DONE
// DONE  | one-cycle completion pulse
module mult_ctrl_param #(
  parameter int                    WIDTH    = 8,
  parameter int                    CW_WIDTH = 16,
  parameter logic [CW_WIDTH-1:0]   CW_IDLE  = 16'h0000,
  parameter logic [CW_WIDTH-1:0]   CW_LOAD  = 16'h0003,
  parameter logic [CW_WIDTH-1:0]   CW_TEST  = 16'h8200,
  parameter logic [CW_WIDTH-1:0]   CW_ADD   = 16'h0201,
  parameter logic [CW_WIDTH-1:0]   CW_SHIFT = 16'h4203,
  parameter logic [CW_WIDTH-1:0]   CW_CHECK = 16'h0249
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_lsb,
  input  logic                         i_zero,
  output logic [CW_WIDTH-1:0]          o_signal,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(WIDTH+1)-1:0]   o_iter
);

  localparam int               CNT_W   = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TEST  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;

`ifdef MULT_CTRL_EARLY_EXIT_EN
  assign last_iter = (cnt == CNT_MAX) || i_zero;
`else
  logic unused_zero;
  assign unused_zero = i_zero;
  assign last_iter   = (cnt == CNT_MAX);
`endif

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = i_start ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt = S_TEST;
      S_TEST:  state_nxt = i_lsb ? S_ADD : S_SHIFT;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_CHECK;
      S_CHECK: state_nxt = last_iter ? S_DONE : S_TEST;
      default: state_nxt = S_IDLE;
    endcase
  end

  // cnt saturates at WIDTH so o_iter can never read past the operand width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD)
        cnt <= '0;
      else if ((state == S_SHIFT) && (cnt != CNT_MAX))
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    o_signal = CW_IDLE;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    case (state)
      S_LOAD:  begin o_signal = CW_LOAD;  o_busy = 1'b1; end
      S_TEST:  begin o_signal = CW_TEST;  o_busy = 1'b1; end
      S_ADD:   begin o_signal = CW_ADD;   o_busy = 1'b1; end
      S_SHIFT: begin o_signal = CW_SHIFT; o_busy = 1'b1; end
      S_CHECK: begin o_signal = CW_CHECK; o_busy = 1'b1; end
      S_DONE:  o_done = 1'b1;
      default: o_signal = CW_IDLE;
    endcase
  end

  assign o_iter = cnt;

endmodule

// File: tb/tb_mult_ctrl_param.sv
// Scoreboard bench for mult_ctrl_param: a behavioural multiplier datapath reacts to the control words,
// expected per-cycle words and per-operation results are queued at issue and popped by a negedge monitor.
module tb_mult_ctrl_param;

  localparam int WIDTH = 8;
  localparam int IW    = $clog2(WIDTH+1);

  localparam logic [15:0] CW_IDLE  = 16'h0000;
  localparam logic [15:0] CW_LOAD  = 16'h0003;
  localparam logic [15:0] CW_TEST  = 16'h8200;
  localparam logic [15:0] CW_ADD   = 16'h0201;
  localparam logic [15:0] CW_SHIFT = 16'h4203;
  localparam logic [15:0] CW_CHECK = 16'h0249;

  typedef struct packed {
    logic [15:0] cw;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct packed {
    logic [31:0]         iter;
    logic [2*WIDTH-1:0]  prod;
  } res_t;

  logic            clk;
  logic            rst;
  logic            i_start;
  logic            i_lsb;
  logic            i_zero;
  logic [15:0]     o_signal;
  logic            o_busy;
  logic            o_done;
  logic [IW-1:0]   o_iter;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  exp_t                exp_q[$];
  res_t                res_q[$];
  logic [2*WIDTH-1:0]  op_q[$];

  // behavioural datapath: multiplier register, shifted multiplicand, accumulator
  logic [WIDTH-1:0]    m;
  logic [2*WIDTH-1:0]  mc;
  logic [2*WIDTH-1:0]  acc;

  assign i_lsb  = m[0];
  assign i_zero = (m == '0);

  mult_ctrl_param #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_lsb    (i_lsb),
    .i_zero   (i_zero),
    .o_signal (o_signal),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_iter   (o_iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_iters(input logic [WIDTH-1:0] b);
    int n;
`ifdef MULT_CTRL_EARLY_EXIT_EN
    n = 1;
    for (int k = 0; k < WIDTH; k++)
      if (b[k]) n = k + 1;
`else
    n = WIDTH;
`endif
    return n;
  endfunction

  function automatic void push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int   n;
    exp_t e;
    res_t r;
    n = exp_iters(b);
    e = '{cw: CW_LOAD, busy: 1'b1, done: 1'b0};
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      e = '{cw: CW_TEST, busy: 1'b1, done: 1'b0};
      exp_q.push_back(e);
      if (b[k]) begin
        e = '{cw: CW_ADD, busy: 1'b1, done: 1'b0};
        exp_q.push_back(e);
      end
      e = '{cw: CW_SHIFT, busy: 1'b1, done: 1'b0};
      exp_q.push_back(e);
      e = '{cw: CW_CHECK, busy: 1'b1, done: 1'b0};
      exp_q.push_back(e);
    end
    e = '{cw: CW_IDLE, busy: 1'b0, done: 1'b1};
    exp_q.push_back(e);
    op_q.push_back({a, b});
    r.iter = 32'(n);
    r.prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    res_q.push_back(r);
  endfunction

  // monitor first, then the datapath reacts to the word of this cycle
  exp_t e_mon;
  res_t r_mon;
  logic [2*WIDTH-1:0] op_mon;
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      compared++;
      if (exp_q.size() > 0) begin
        e_mon = exp_q.pop_front();
        if ({o_signal, o_busy, o_done} !== {e_mon.cw, e_mon.busy, e_mon.done}) begin
          mismatched++;
          $display("FAIL cycle_word t=%0t: got cw=%h busy=%b done=%b, want cw=%h busy=%b done=%b",
                   $time, o_signal, o_busy, o_done, e_mon.cw, e_mon.busy, e_mon.done);
        end
      end else if ({o_signal, o_busy, o_done} !== {CW_IDLE, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL idle_word t=%0t: got cw=%h busy=%b done=%b, want cw=%h busy=0 done=0",
                 $time, o_signal, o_busy, o_done, CW_IDLE);
      end
      if (o_done) begin
        compared++;
        if (res_q.size() == 0) begin
          mismatched++;
          $display("FAIL done_unexpected t=%0t: got o_done=1, want no pending operation", $time);
        end else begin
          r_mon = res_q.pop_front();
          if (32'(o_iter) !== r_mon.iter) begin
            mismatched++;
            $display("FAIL iter t=%0t: got %0d, want %0d", $time, o_iter, r_mon.iter);
          end
          compared++;
          if (acc !== r_mon.prod) begin
            mismatched++;
            $display("FAIL product t=%0t: got %0d, want %0d", $time, acc, r_mon.prod);
          end
        end
      end
      if (o_signal == CW_LOAD) begin
        if (op_q.size() > 0) begin
          op_mon = op_q.pop_front();
          mc  = (2*WIDTH)'(op_mon[2*WIDTH-1:WIDTH]);
          m   = op_mon[WIDTH-1:0];
          acc = '0;
        end
      end else if (o_signal == CW_ADD) begin
        acc = acc + mc;
      end else if (o_signal == CW_SHIFT) begin
        mc = mc << 1;
        m  = m >> 1;
      end
    end
  end

  task automatic run_batch(input int n, input bit held, input bit fixed, input logic [WIDTH-1:0] fb);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    exp_t             e;
    int               guard;
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      a = WIDTH'($urandom);
      b = fixed ? fb : WIDTH'($urandom);
      if (i > 0) begin
        e = '{cw: CW_IDLE, busy: 1'b0, done: 1'b0};
        exp_q.push_back(e);
      end
      push_op(a, b);
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 5000) begin
      if (held && exp_q.size() > 2)       i_start = 1'b1;
      else if (!held && exp_q.size() > 3) i_start = 1'($urandom_range(0, 1));
      else                                i_start = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    i_start = 1'b0;
    if (guard >= 5000) begin
      mismatched++;
      compared++;
      $display("FAIL timeout: got %0d expected entries still pending, want 0", exp_q.size());
      exp_q.delete(); res_q.delete(); op_q.delete();
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string name);
    compared++;
    if ({o_signal, o_busy, o_done, o_iter} !== {CW_IDLE, 1'b0, 1'b0, IW'(0)}) begin
      mismatched++;
      $display("FAIL %s: got cw=%h busy=%b done=%b iter=%0d, want cw=%h busy=0 done=0 iter=0",
               name, o_signal, o_busy, o_done, o_iter, CW_IDLE);
    end
  endtask

  task automatic reset_mid_add;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               target;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom) | WIDTH'(8'h84);
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    push_op(a, b);
    // cycle index (LOAD = 1) of the ADD in the third iteration
    target = 1 + (3 + int'(b[0])) + (3 + int'(b[1])) + 2;
    repeat (target - 1) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle_outputs("reset_mid_add");
    exp_q.delete(); res_q.delete(); op_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    i_start = 1'b0;
    m       = '0;
    mc      = '0;
    acc     = '0;
    #2 check_idle_outputs("reset_state");
    @(posedge clk); #1 rst = 1'b0;

    run_batch(1, 1'b0, 1'b1, 8'h00);     // lsb always 0
    run_batch(1, 1'b0, 1'b1, 8'h0B);     // lsb 1,1,0,1,0...
    run_batch(1, 1'b0, 1'b1, 8'hFF);
    run_batch(1, 1'b0, 1'b1, 8'h80);
    for (int i = 0; i < 10; i++)
      run_batch(1, 1'b0, 1'b0, '0);
    run_batch(3, 1'b1, 1'b0, '0);        // i_start held high
    reset_mid_add();
    repeat (3) @(posedge clk);
    run_batch(1, 1'b0, 1'b1, 8'hA5);     // full run after abort
    run_batch(2, 1'b1, 1'b0, '0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_ctrl_param.md
Name: mult_ctrl_param

Overview:
Parametrised control FSM for the shift-and-add multiplier datapath. It sequences load, test-LSB, add, shift and check steps, emitting one control word per state. Compared with the fixed controller it adds a start/busy/done handshake, an iteration counter bounded by WIDTH, and configurable control-word constants. It sits beside the ALU/mux/register-file datapath and drives its select and write lines.

Parameters:
WIDTH, 8, operand width; number of shift iterations (>=2)
CW_WIDTH, 16, control word width
CW_IDLE, 16'h0000, control word in IDLE and DONE
CW_LOAD, 16'h0003, load operands into working registers
CW_TEST, 16'h8200, present multiplier LSB to i_lsb
CW_ADD, 16'h0201, accumulate multiplicand
CW_SHIFT, 16'h4203, shift product/multiplier
CW_CHECK, 16'h0249, evaluate termination

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
i_start  in  1  start request, sampled in IDLE only
i_lsb  in  1  multiplier LSB (parity) from datapath
i_zero  in  1  multiplier register equals zero
o_signal  out  CW_WIDTH  control word to datapath
o_busy  out  1  high in LOAD, TEST, ADD, SHIFT, CHECK
o_done  out  1  one-cycle pulse in DONE
o_iter  out  $clog2(WIDTH+1)  completed iteration count

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0; o_signal=CW_IDLE, o_busy=0, o_done=0, o_iter=0. Reset mid-operation aborts immediately; no done pulse.
- State register and cnt update on posedge clk; o_signal/o_busy/o_done are Moore outputs decoded from state only.
- States and transitions:
  - IDLE: CW_IDLE; i_start=1 -> LOAD, else stay.
  - LOAD: CW_LOAD; cnt<=0; -> TEST.
  - TEST: CW_TEST; i_lsb=1 -> ADD, else -> SHIFT.
  - ADD: CW_ADD; -> SHIFT.
  - SHIFT: CW_SHIFT; cnt<=cnt+1; -> CHECK.
  - CHECK: CW_CHECK; cnt==WIDTH -> DONE, else -> TEST.
  - DONE: CW_IDLE, o_done=1; -> IDLE.
- Unused state encodings: next state IDLE, output CW_IDLE.
- Iteration cost: 3 cycles (lsb=0) or 4 cycles (lsb=1). Total, counting LOAD as cycle 1 after the start edge: 1 + sum(3+lsb_k) + 1; o_done in the last cycle.
- i_start while busy or in DONE: ignored, not queued. i_start held high: new operation begins the cycle after DONE (IDLE lasts 1 cycle).
- cnt never exceeds WIDTH; o_iter = cnt, holds final value until next LOAD.
- i_lsb sampled only in TEST; i_zero only in CHECK.

Optional Feature:
MULT_CTRL_EARLY_EXIT_EN: when defined, CHECK -> DONE if cnt==WIDTH OR i_zero=1 (multiplier exhausted), and o_iter reports the actual iterations run. When undefined, i_zero is ignored and exactly WIDTH iterations always run.

Test Plan:
- Reset in IDLE, rst=1 -> o_signal=16'h0000, o_busy=0, o_done=0, o_iter=0.
- WIDTH=8, i_start pulse, i_lsb=0 always, feature off -> o_busy for 25 cycles, o_done in cycle 26, o_iter=8, CW_ADD never issued.
- WIDTH=4, i_lsb sequence 1,1,0,1 -> control words LOAD,(TEST,ADD,SHIFT,CHECK)x2,TEST,SHIFT,CHECK,TEST,ADD,SHIFT,CHECK; o_done in cycle 17.
- Feature on, WIDTH=8, i_zero=1 at first CHECK, i_lsb=0 -> o_done in cycle 5, o_iter=1.
- rst asserted asynchronously during ADD in iteration 3 -> same cycle o_signal=CW_IDLE, o_busy=0; no o_done; next i_start runs a full 8 iterations.
- i_start held high continuously -> back-to-back operations, exactly one IDLE cycle between DONE and next LOAD; i_start pulses during busy ignored.
